datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Multi-cycle controller that fetches 32-bit instruction words over a valid/ready handshake and sequences the ALU datapath.
- Drives all datapath control inputs per instruction: immediate, buff_en, enable, control1, control2, imm_control, opcode.
- Replaces the fixed-program FSM with an instruction-driven sequencer between the instruction source and the ALU datapath.

Parameters:
- NREGS, 16, number of datapath registers; width of enable one-hot.
- IDLE_SEL, 5'h1F, control1/control2 value meaning "no register driving the bus".
- IMM_BIT, 4, opcode bit that selects the immediate-operand form.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching from IDLE or HALTED.
- instr_valid  in  1  instruction word available.
- instr_data  in  32  [31:24] opcode, [23:20] dest reg, [19:16] src reg, [15:0] immediate.
- instr_ready  out  1  sequencer accepts instr_data this cycle.
- immediate  out  16  immediate operand to datapath.
- buff_en  out  1  result buffer drives the bus (WRITE state only).
- enable  out  16  one-hot register write enable.
- control1  out  5  operand-A / destination mux select.
- control2  out  5  operand-B mux select.
- imm_control  out  1  select immediate instead of control2 register.
- opcode  out  8  ALU opcode.
- busy  out  1  high in FETCH, EXEC and WRITE.
- halted  out  1  high in HALTED.
- retired_count  out  16  number of instructions completed, including NOPs.

Behaviour:
- All outputs are registered.
- Reset values: instr_ready=0, immediate=0, buff_en=0, enable=0, control1=control2=IDLE_SEL, imm_control=0, opcode=0, busy=0, halted=0, retired_count=0; state=IDLE.
- States: IDLE, FETCH, EXEC, WRITE, HALTED.
- IDLE: start -> FETCH. All other inputs are ignored.
- FETCH: instr_ready=1.
  - A handshake occurs when instr_valid=1 and instr_ready=1; the instruction is latched.
  - No handshake: remain in FETCH indefinitely.
  - Opcode 8'hFF (HALT): -> HALTED, not counted.
  - Any other opcode: -> EXEC.
- EXEC, one cycle:
  - opcode = instr[31:24], control1 = {1'b0,dest}, immediate = instr[15:0], imm_control = opcode[IMM_BIT].
  - control2 = IDLE_SEL if imm_control=1, else {1'b0,src}.
  - enable = 0, buff_en = 0.
  - Opcode 8'h00 (NOP): retired_count++ and -> FETCH; WRITE is skipped.
  - Otherwise -> WRITE.
- WRITE, one cycle: opcode, control1, control2, imm_control and immediate hold their EXEC values. buff_en=1, enable = 1<<dest, retired_count++, then -> FETCH.
- Latency: handshake at cycle N, EXEC at N+1, WRITE at N+2, next FETCH (instr_ready=1) at N+3. A NOP is back in FETCH at N+2.
- On entry to FETCH or HALTED: enable=0, buff_en=0, control1=control2=IDLE_SEL, imm_control=0. opcode and immediate hold their last values.
- HALTED: halted=1, busy=0.
  - start -> FETCH and clears halted.
  - retired_count is preserved; it is cleared only by reset.
- start while busy is ignored; a start in the same cycle as a HALT handshake is ignored.
- retired_count wraps 16'hFFFF -> 16'h0000.
- enable never has more than one bit set. buff_en is high only when enable is nonzero.
- Reset asserted mid-instruction: outputs go to their reset values immediately (asynchronously), the partially executed instruction is discarded, and the block waits for start.

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH, EXEC, WRITE, HALTED);
  - OP_NOP = 8'h00, OP_HALT = 8'hFF;
  - instruction field positions (OPC_MSB/LSB, DST_MSB/LSB, SRC_MSB/LSB, IMM_MSB/LSB);
  - IDLE_SEL and IMM_BIT defaults.
- One sub-module: reg_onehot_decoder, a 4-bit dest index plus valid in, 16-bit one-hot out; zero when valid=0. Instantiated to produce enable.

Test Plan:
- Reset then start; present 32'h01_3_2_0000 with valid held -> handshake at cycle N; at N+1 opcode=8'h01, control1=5'h03, control2=5'h02, imm_control=0; at N+2 enable=16'h0008, buff_en=1; retired_count=1; instr_ready=1 at N+3.
- Immediate form 32'h11_5_0_ABCD -> EXEC: imm_control=1, immediate=16'hABCD, control2=5'h1F; WRITE: enable=16'h0020.
- NOP 32'h00_7_7_0000 -> no cycle with buff_en=1 or enable nonzero; back in FETCH 2 cycles after the handshake; retired_count increments.
- HALT 32'hFF_0_0_0000 -> halted=1, busy=0, retired_count unchanged; start while halted -> FETCH resumes with the count preserved.
- Backpressure: instr_valid low for 5 cycles in FETCH -> instr_ready stays 1 and enable stays 0; start pulses during EXEC or WRITE have no effect.
- Assert reset during WRITE with enable=16'h0001 -> enable=0, buff_en=0 and retired_count=0 before the next clock edge; the block waits for start.

Source files
------------

// File: rtl/datapath_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_pkg
// Shared definitions for the instruction-driven datapath sequencer:
//   - sequencer state encoding
//   - special opcodes (NOP, HALT)
//   - instruction word field positions
//   - default parameter values for the idle mux select and immediate flag bit
// -----------------------------------------------------------------------------
package datapath_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      WRITE  = 3'd3,
      HALTED = 3'd4
   } state_t;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_HALT = 8'hFF;

   // Instruction word layout: [31:24] opcode, [23:20] dest, [19:16] src, [15:0] imm
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 24;
   localparam int DST_MSB = 23;
   localparam int DST_LSB = 20;
   localparam int SRC_MSB = 19;
   localparam int SRC_LSB = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam int         NREGS_DEFAULT    = 16;
   localparam logic [4:0] IDLE_SEL_DEFAULT = 5'h1F;
   localparam int         IMM_BIT_DEFAULT  = 4;

endpackage

// File: rtl/datapath_sequencer_reg_onehot_decoder.sv
// -----------------------------------------------------------------------------
// reg_onehot_decoder
// Converts a 4-bit register index into a one-hot register write enable.
// Output is all zeros when i_valid is low, so at most one bit is ever set.
// Ports:
//   i_idx    in  4      destination register index
//   i_valid  in  1      decode enable
//   o_onehot out NREGS  one-hot write enable
// -----------------------------------------------------------------------------
module reg_onehot_decoder
   import datapath_sequencer_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic [3:0]       i_idx,
   input  logic             i_valid,
   output logic [NREGS-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_valid) begin
         o_onehot[i_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Fetches 32-bit instruction words over a valid/ready handshake and sequences
// the ALU datapath controls through FETCH -> EXEC -> WRITE. NOP skips WRITE,
// HALT parks the sequencer in HALTED until the next start pulse.
// Ports:
//   clk, reset (async, active-high), start (one-cycle pulse)
//   instr_valid/instr_data in, instr_ready out : instruction handshake
//   immediate, buff_en, enable, control1, control2, imm_control, opcode :
//       registered datapath controls
//   busy, halted, retired_count : status
// -----------------------------------------------------------------------------
module datapath_sequencer
   import datapath_sequencer_pkg::*;
#(
   parameter int         NREGS    = NREGS_DEFAULT,
   parameter logic [4:0] IDLE_SEL = IDLE_SEL_DEFAULT,
   parameter int         IMM_BIT  = IMM_BIT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             instr_valid,
   input  logic [31:0]      instr_data,
   output logic             instr_ready,
   output logic [15:0]      immediate,
   output logic             buff_en,
   output logic [NREGS-1:0] enable,
   output logic [4:0]       control1,
   output logic [4:0]       control2,
   output logic             imm_control,
   output logic [7:0]       opcode,
   output logic             busy,
   output logic             halted,
   output logic [15:0]      retired_count
);

   state_t           r_state,       w_state_nxt;
   logic [3:0]       r_dst,         w_dst_nxt;
   logic             r_instr_ready, w_instr_ready_nxt;
   logic [15:0]      r_immediate,   w_immediate_nxt;
   logic             r_buff_en,     w_buff_en_nxt;
   logic [NREGS-1:0] r_enable,      w_enable_nxt;
   logic [4:0]       r_control1,    w_control1_nxt;
   logic [4:0]       r_control2,    w_control2_nxt;
   logic             r_imm_control, w_imm_control_nxt;
   logic [7:0]       r_opcode,      w_opcode_nxt;
   logic             r_busy,        w_busy_nxt;
   logic             r_halted,      w_halted_nxt;
   logic [15:0]      r_retired,     w_retired_nxt;

   logic             w_hs;
   logic             w_imm_form;
   logic             w_dec_valid;
   logic [NREGS-1:0] w_dec_onehot;

   // Write enable is decoded from the latched destination during EXEC so it
   // lands in the WRITE-cycle register together with buff_en.
   assign w_dec_valid = (r_state == EXEC) && (r_opcode != OP_NOP);

   reg_onehot_decoder #(
      .NREGS(NREGS)
   ) u_dec (
      .i_idx   (r_dst),
      .i_valid (w_dec_valid),
      .o_onehot(w_dec_onehot)
   );

   always_comb begin
      w_hs       = (r_state == FETCH) && r_instr_ready && instr_valid;
      w_imm_form = instr_data[OPC_LSB + IMM_BIT];

      w_state_nxt       = r_state;
      w_dst_nxt         = r_dst;
      w_instr_ready_nxt = r_instr_ready;
      w_immediate_nxt   = r_immediate;
      w_buff_en_nxt     = r_buff_en;
      w_enable_nxt      = r_enable;
      w_control1_nxt    = r_control1;
      w_control2_nxt    = r_control2;
      w_imm_control_nxt = r_imm_control;
      w_opcode_nxt      = r_opcode;
      w_busy_nxt        = r_busy;
      w_halted_nxt      = r_halted;
      w_retired_nxt     = r_retired;

      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = FETCH;
         end
         FETCH: begin
            if (w_hs) begin
               w_dst_nxt = instr_data[DST_MSB:DST_LSB];
               if (instr_data[OPC_MSB:OPC_LSB] == OP_HALT) begin
                  w_state_nxt = HALTED;
               end else begin
                  w_state_nxt       = EXEC;
                  w_instr_ready_nxt = 1'b0;
                  w_opcode_nxt      = instr_data[OPC_MSB:OPC_LSB];
                  w_control1_nxt    = {1'b0, instr_data[DST_MSB:DST_LSB]};
                  w_immediate_nxt   = instr_data[IMM_MSB:IMM_LSB];
                  w_imm_control_nxt = w_imm_form;
                  w_control2_nxt    = w_imm_form ? IDLE_SEL
                                                 : {1'b0, instr_data[SRC_MSB:SRC_LSB]};
               end
            end
         end
         EXEC: begin
            // Count is bumped here so it is visible in the WRITE cycle; a NOP
            // retires directly from EXEC.
            w_retired_nxt = r_retired + 16'd1;
            if (r_opcode == OP_NOP) begin
               w_state_nxt = FETCH;
            end else begin
               w_state_nxt   = WRITE;
               w_buff_en_nxt = 1'b1;
               w_enable_nxt  = w_dec_onehot;
            end
         end
         WRITE: begin
            w_state_nxt = FETCH;
         end
         HALTED: begin
            if (start) w_state_nxt = FETCH;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Entry actions shared by every path into FETCH / HALTED; opcode and
      // immediate intentionally keep their last values.
      if ((w_state_nxt == FETCH) && (r_state != FETCH)) begin
         w_instr_ready_nxt = 1'b1;
         w_busy_nxt        = 1'b1;
         w_halted_nxt      = 1'b0;
         w_enable_nxt      = '0;
         w_buff_en_nxt     = 1'b0;
         w_control1_nxt    = IDLE_SEL;
         w_control2_nxt    = IDLE_SEL;
         w_imm_control_nxt = 1'b0;
      end
      if ((w_state_nxt == HALTED) && (r_state != HALTED)) begin
         w_instr_ready_nxt = 1'b0;
         w_busy_nxt        = 1'b0;
         w_halted_nxt      = 1'b1;
         w_enable_nxt      = '0;
         w_buff_en_nxt     = 1'b0;
         w_control1_nxt    = IDLE_SEL;
         w_control2_nxt    = IDLE_SEL;
         w_imm_control_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dst         <= '0;
         r_instr_ready <= 1'b0;
         r_immediate   <= '0;
         r_buff_en     <= 1'b0;
         r_enable      <= '0;
         r_control1    <= IDLE_SEL;
         r_control2    <= IDLE_SEL;
         r_imm_control <= 1'b0;
         r_opcode      <= '0;
         r_busy        <= 1'b0;
         r_halted      <= 1'b0;
         r_retired     <= '0;
      end else begin
         r_dst         <= w_dst_nxt;
         r_instr_ready <= w_instr_ready_nxt;
         r_immediate   <= w_immediate_nxt;
         r_buff_en     <= w_buff_en_nxt;
         r_enable      <= w_enable_nxt;
         r_control1    <= w_control1_nxt;
         r_control2    <= w_control2_nxt;
         r_imm_control <= w_imm_control_nxt;
         r_opcode      <= w_opcode_nxt;
         r_busy        <= w_busy_nxt;
         r_halted      <= w_halted_nxt;
         r_retired     <= w_retired_nxt;
      end
   end

   assign instr_ready   = r_instr_ready;
   assign immediate     = r_immediate;
   assign buff_en       = r_buff_en;
   assign enable        = r_enable;
   assign control1      = r_control1;
   assign control2      = r_control2;
   assign imm_control   = r_imm_control;
   assign opcode        = r_opcode;
   assign busy          = r_busy;
   assign halted        = r_halted;
   assign retired_count = r_retired;

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Scenario-driven bench for datapath_sequencer: expected datapath controls are
// computed from each instruction word when it is issued, queued, and popped
// when the sequencer reaches EXEC/WRITE.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic        instr_ready;
   logic [15:0] immediate;
   logic        buff_en;
   logic [15:0] enable;
   logic [4:0]  control1;
   logic [4:0]  control2;
   logic        imm_control;
   logic [7:0]  opcode;
   logic        busy;
   logic        halted;
   logic [15:0] retired_count;

   datapath_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .instr_valid  (instr_valid),
      .instr_data   (instr_data),
      .instr_ready  (instr_ready),
      .immediate    (immediate),
      .buff_en      (buff_en),
      .enable       (enable),
      .control1     (control1),
      .control2     (control2),
      .imm_control  (imm_control),
      .opcode       (opcode),
      .busy         (busy),
      .halted       (halted),
      .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  opc;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        imm_ctl;
      logic [15:0] imm;
      logic [15:0] en;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_retired = 0;

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      e.opc     = w[31:24];
      e.c1      = {1'b0, w[23:20]};
      e.imm_ctl = w[28];
      e.c2      = w[28] ? 5'h1F : {1'b0, w[19:16]};
      e.imm     = w[15:0];
      e.en      = (w[31:24] == 8'h00) ? 16'h0000 : (16'h0001 << w[23:20]);
      return e;
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Presents one word, waits (bounded) for the handshake, and returns at the
   // falling edge of the EXEC cycle.
   task automatic send(input logic [31:0] w);
      int n = 0;
      @(negedge clk);
      instr_data  = w;
      instr_valid = 1'b1;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_wait instr_ready=%b required=1", instr_ready);
      end
      if (w[31:24] != 8'hFF) sb.push_back(model(w));
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({instr_ready, immediate, buff_en, enable, control1, control2, imm_control, opcode, busy, halted, retired_count}
          !== {1'b0, 16'h0, 1'b0, 16'h0, 5'h1F, 5'h1F, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL reset_values got rdy=%b imm=%h be=%b en=%h c1=%h c2=%h ic=%b op=%h busy=%b halt=%b cnt=%h required 0/0/0/0/1f/1f/0/0/0/0/0",
                  instr_ready, immediate, buff_en, enable, control1, control2, imm_control, opcode, busy, halted, retired_count);
      end
      reset = 1'b0;
      instr_valid = 1'b1; instr_data = 32'h0132_0000;
      repeat (3) @(negedge clk);
      checks++;
      if ({instr_ready, busy} !== 2'b00) begin
         errors++;
         $display("FAIL idle_ignores_valid rdy/busy=%b required=00", {instr_ready, busy});
      end
      instr_valid = 1'b0;
      pulse_start();
      checks++;
      if ({instr_ready, busy, halted} !== 3'b110) begin
         errors++;
         $display("FAIL start_to_fetch rdy/busy/halt=%b required=110", {instr_ready, busy, halted});
      end
   endtask

   task automatic test_alu_ops();
      logic [31:0] tbl [4];
      exp_t e;
      tbl[0] = 32'h0132_0000;
      tbl[1] = 32'h1150_ABCD;
      tbl[2] = 32'h02F1_1234;
      tbl[3] = 32'h1300_FFFF;
      for (int i = 0; i < 4; i++) begin
         send(tbl[i]);
         e = sb.pop_front();
         checks++;
         if ({opcode, control1, control2, imm_control, immediate, enable, buff_en, instr_ready, busy}
             !== {e.opc, e.c1, e.c2, e.imm_ctl, e.imm, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL exec%0d got op=%h c1=%h c2=%h ic=%b imm=%h en=%h be=%b rdy=%b required op=%h c1=%h c2=%h ic=%b imm=%h en=0 be=0 rdy=0",
                     i, opcode, control1, control2, imm_control, immediate, enable, buff_en, instr_ready,
                     e.opc, e.c1, e.c2, e.imm_ctl, e.imm);
         end
         exp_retired++;
         @(negedge clk);
         checks++;
         if ({enable, buff_en, retired_count, opcode, control1, control2, imm_control, immediate}
             !== {e.en, 1'b1, exp_retired[15:0], e.opc, e.c1, e.c2, e.imm_ctl, e.imm}) begin
            errors++;
            $display("FAIL write%0d got en=%h be=%b cnt=%0d op=%h c1=%h c2=%h required en=%h be=1 cnt=%0d op=%h c1=%h c2=%h",
                     i, enable, buff_en, retired_count, opcode, control1, control2,
                     e.en, exp_retired, e.opc, e.c1, e.c2);
         end
         @(negedge clk);
         checks++;
         if ({instr_ready, enable, buff_en, control1, control2, imm_control, opcode, immediate}
             !== {1'b1, 16'h0, 1'b0, 5'h1F, 5'h1F, 1'b0, e.opc, e.imm}) begin
            errors++;
            $display("FAIL refetch%0d got rdy=%b en=%h be=%b c1=%h c2=%h ic=%b op=%h imm=%h required 1/0/0/1f/1f/0/%h/%h",
                     i, instr_ready, enable, buff_en, control1, control2, imm_control, opcode, immediate, e.opc, e.imm);
         end
      end
   endtask

   task automatic test_nop();
      exp_t e;
      send(32'h0077_0000);
      e = sb.pop_front();
      checks++;
      if ({opcode, control1, enable, buff_en} !== {e.opc, e.c1, 16'h0, 1'b0}) begin
         errors++;
         $display("FAIL nop_exec got op=%h c1=%h en=%h be=%b required op=%h c1=%h en=0 be=0",
                  opcode, control1, enable, buff_en, e.opc, e.c1);
      end
      exp_retired++;
      @(negedge clk);
      checks++;
      if ({instr_ready, enable, buff_en, retired_count} !== {1'b1, 16'h0, 1'b0, exp_retired[15:0]}) begin
         errors++;
         $display("FAIL nop_return got rdy=%b en=%h be=%b cnt=%0d required rdy=1 en=0 be=0 cnt=%0d",
                  instr_ready, enable, buff_en, retired_count, exp_retired);
      end
   endtask

   task automatic test_halt();
      // HALT handshake with a simultaneous start: the start must be ignored.
      @(negedge clk);
      instr_data = 32'hFF00_0000; instr_valid = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0; start = 1'b0;
      checks++;
      if ({halted, busy, instr_ready, enable, buff_en, control1, retired_count}
          !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 5'h1F, exp_retired[15:0]}) begin
         errors++;
         $display("FAIL halt_enter got halt=%b busy=%b rdy=%b en=%h be=%b c1=%h cnt=%0d required 1/0/0/0/0/1f/%0d",
                  halted, busy, instr_ready, enable, buff_en, control1, retired_count, exp_retired);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({halted, instr_ready} !== 2'b10) begin
         errors++;
         $display("FAIL halt_stays halt/rdy=%b required=10", {halted, instr_ready});
      end
      pulse_start();
      checks++;
      if ({instr_ready, busy, halted, retired_count} !== {1'b1, 1'b1, 1'b0, exp_retired[15:0]}) begin
         errors++;
         $display("FAIL halt_resume got rdy=%b busy=%b halt=%b cnt=%0d required 1/1/0/%0d",
                  instr_ready, busy, halted, retired_count, exp_retired);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      instr_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({instr_ready, enable, busy} !== {1'b1, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL stall%0d got rdy=%b en=%h busy=%b required rdy=1 en=0 busy=1",
                     i, instr_ready, enable, busy);
         end
      end
      send(32'h03A4_0000);
      e = sb.pop_front();
      start = 1'b1;
      exp_retired++;
      @(negedge clk);
      checks++;
      if ({enable, buff_en, opcode, retired_count} !== {e.en, 1'b1, e.opc, exp_retired[15:0]}) begin
         errors++;
         $display("FAIL start_in_exec got en=%h be=%b op=%h cnt=%0d required en=%h be=1 op=%h cnt=%0d",
                  enable, buff_en, opcode, retired_count, e.en, e.opc, exp_retired);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({instr_ready, busy, halted, enable, retired_count} !== {1'b1, 1'b1, 1'b0, 16'h0, exp_retired[15:0]}) begin
         errors++;
         $display("FAIL start_in_write got rdy=%b busy=%b halt=%b en=%h cnt=%0d required 1/1/0/0/%0d",
                  instr_ready, busy, halted, enable, retired_count, exp_retired);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] tbl [3];
      exp_t e;
      tbl[0] = 32'h0411_0000;
      tbl[1] = 32'h0000_0000;
      tbl[2] = 32'h14C2_5A5A;
      for (int i = 0; i < 3; i++) begin
         send(tbl[i]);
         e = sb.pop_front();
         exp_retired++;
         checks++;
         if ({opcode, control2, immediate} !== {e.opc, e.c2, e.imm}) begin
            errors++;
            $display("FAIL b2b_exec%0d got op=%h c2=%h imm=%h required op=%h c2=%h imm=%h",
                     i, opcode, control2, immediate, e.opc, e.c2, e.imm);
         end
         if (e.en != 16'h0) begin
            @(negedge clk);
            checks++;
            if ({enable, buff_en} !== {e.en, 1'b1}) begin
               errors++;
               $display("FAIL b2b_write%0d got en=%h be=%b required en=%h be=1", i, enable, buff_en, e.en);
            end
         end
         @(negedge clk);
         checks++;
         if ({instr_ready, enable, retired_count} !== {1'b1, 16'h0, exp_retired[15:0]}) begin
            errors++;
            $display("FAIL b2b_ready%0d got rdy=%b en=%h cnt=%0d required rdy=1 en=0 cnt=%0d",
                     i, instr_ready, enable, retired_count, exp_retired);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      send(32'h0500_0000);
      e = sb.pop_front();
      @(negedge clk);
      checks++;
      if ({enable, buff_en} !== {16'h0001, 1'b1}) begin
         errors++;
         $display("FAIL mid_write got en=%h be=%b required en=0001 be=1", enable, buff_en);
      end
      reset = 1'b1;
      #1;
      exp_retired = 0;
      checks++;
      if ({enable, buff_en, retired_count, instr_ready, control1, busy}
          !== {16'h0, 1'b0, 16'h0, 1'b0, 5'h1F, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got en=%h be=%b cnt=%0d rdy=%b c1=%h busy=%b required 0/0/0/0/1f/0",
                  enable, buff_en, retired_count, instr_ready, control1, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      instr_valid = 1'b1; instr_data = 32'h0132_0000;
      repeat (3) @(negedge clk);
      checks++;
      if ({instr_ready, busy, enable} !== {1'b0, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL wait_start got rdy=%b busy=%b en=%h required 0/0/0", instr_ready, busy, enable);
      end
      instr_valid = 1'b0;
      pulse_start();
      send(32'h0132_0000);
      e = sb.pop_front();
      exp_retired++;
      @(negedge clk);
      checks++;
      if ({enable, retired_count} !== {e.en, exp_retired[15:0]}) begin
         errors++;
         $display("FAIL post_reset got en=%h cnt=%0d required en=%h cnt=%0d",
                  enable, retired_count, e.en, exp_retired);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu_ops();
      test_nop();
      test_halt();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
